// File: rtl/sayac_izleyici.sv
// sayac_izleyici: monitors the sayac counter's sonuc stream, buffers each
// sample taken while mesgul is high in a FIFO drained over valid/ready, and
// emits a one-cycle summary (count, sum, min, max, hazir, overflow) when a
// counting session ends.
module sayac_izleyici #(
    parameter int DERINLIK = 8,
    parameter int TOPLAM_W = 20
) (
    input  logic                      saat,
    input  logic                      reset,
    input  logic                      mesgul_giris,
    input  logic [7:0]                sonuc_giris,
    input  logic                      hazir_giris,
    output logic [7:0]                veri_cikis,
    output logic                      veri_gecerli,
    input  logic                      veri_al,
    output logic [$clog2(DERINLIK):0] doluluk,
    output logic                      ozet_gecerli,
    output logic [9:0]                adim_sayisi,
    output logic [TOPLAM_W-1:0]       toplam,
    output logic [7:0]                en_kucuk,
    output logic [7:0]                en_buyuk,
    output logic                      hazir_goruldu,
    output logic                      tasma
);

    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0] DOLU = (AW+1)'(DERINLIK);

    localparam logic [1:0] BOS   = 2'd0;
    localparam logic [1:0] TOPLA = 2'd1;
    localparam logic [1:0] OZET  = 2'd2;

    logic [1:0]          durum, sonraki_durum;
    logic [7:0]          bellek [DERINLIK];
    logic [AW-1:0]       yaz_ptr, oku_ptr;

    logic [9:0]          canli_adim;
    logic [TOPLAM_W-1:0] canli_toplam;
    logic [7:0]          canli_min, canli_max;
    logic                canli_hazir, canli_tasma;

    logic ornek, yeni_oturum, oturum_bitti, cek, dolu, yaz, dusur;

    // Sampling, FIFO handshake and overflow decode
    always_comb begin
        ornek        = mesgul_giris;
        yeni_oturum  = mesgul_giris && (durum != TOPLA);
        oturum_bitti = !mesgul_giris && (durum == TOPLA);
        cek          = veri_gecerli && veri_al;
        dolu         = (doluluk == DOLU);
        // A pop on the same edge frees the slot, so a full FIFO still accepts
        yaz          = ornek && (!dolu || cek);
        dusur        = ornek && dolu && !cek;
    end

    // Session FSM next-state
    always_comb begin
        sonraki_durum = BOS;
        case (durum)
            BOS:     sonraki_durum = mesgul_giris ? TOPLA : BOS;
            TOPLA:   sonraki_durum = mesgul_giris ? TOPLA : OZET;
            OZET:    sonraki_durum = mesgul_giris ? TOPLA : BOS;
            default: sonraki_durum = BOS;
        endcase
    end

    assign ozet_gecerli = (durum == OZET);
    assign veri_gecerli = (doluluk != '0);
    assign veri_cikis   = bellek[oku_ptr];

    // State register
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) durum <= BOS;
        else        durum <= sonraki_durum;
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DERINLIK; i++) bellek[i] <= '0;
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else begin
            if (yaz) begin
                bellek[yaz_ptr] <= sonuc_giris;
                yaz_ptr         <= yaz_ptr + AW'(1);
            end
            if (cek) oku_ptr <= oku_ptr + AW'(1);
            case ({yaz, cek})
                2'b10:   doluluk <= doluluk + (AW+1)'(1);
                2'b01:   doluluk <= doluluk - (AW+1)'(1);
                default: doluluk <= doluluk;
            endcase
        end
    end

    // Live session accumulators; the first sample of a session reinitialises them
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            canli_adim   <= '0;
            canli_toplam <= '0;
            canli_min    <= '0;
            canli_max    <= '0;
            canli_hazir  <= 1'b0;
            canli_tasma  <= 1'b0;
        end else if (yeni_oturum) begin
            canli_adim   <= 10'd1;
            canli_toplam <= TOPLAM_W'(sonuc_giris);
            canli_min    <= sonuc_giris;
            canli_max    <= sonuc_giris;
            canli_hazir  <= hazir_giris;
            canli_tasma  <= dusur;
        end else if (ornek) begin
            if (canli_adim != '1) canli_adim <= canli_adim + 10'd1;
            canli_toplam <= canli_toplam + TOPLAM_W'(sonuc_giris);
            if (sonuc_giris < canli_min) canli_min <= sonuc_giris;
            if (sonuc_giris > canli_max) canli_max <= sonuc_giris;
            canli_hazir  <= canli_hazir | hazir_giris;
            canli_tasma  <= canli_tasma | dusur;
        end
    end

    // Summary registers, loaded when a session ends and held until the next one
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            adim_sayisi   <= '0;
            toplam        <= '0;
            en_kucuk      <= '0;
            en_buyuk      <= '0;
            hazir_goruldu <= 1'b0;
            tasma         <= 1'b0;
        end else if (oturum_bitti) begin
            adim_sayisi   <= canli_adim;
            toplam        <= canli_toplam;
            en_kucuk      <= canli_min;
            en_buyuk      <= canli_max;
            hazir_goruldu <= canli_hazir;
            tasma         <= canli_tasma;
        end
    end

endmodule

// File: tb/tb_sayac_izleyici.sv
// Directed testbench for sayac_izleyici with hand-computed expectations.
module tb_sayac_izleyici;

    logic        saat = 1'b0;
    logic        reset = 1'b0;
    logic        mesgul_giris = 1'b0;
    logic [7:0]  sonuc_giris = '0;
    logic        hazir_giris = 1'b0;
    logic        veri_al = 1'b0;
    logic [7:0]  veri_cikis;
    logic        veri_gecerli;
    logic [3:0]  doluluk;
    logic        ozet_gecerli;
    logic [9:0]  adim_sayisi;
    logic [19:0] toplam;
    logic [7:0]  en_kucuk, en_buyuk;
    logic        hazir_goruldu, tasma;

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    sayac_izleyici #(.DERINLIK(8), .TOPLAM_W(20)) dut (
        .saat(saat), .reset(reset), .mesgul_giris(mesgul_giris),
        .sonuc_giris(sonuc_giris), .hazir_giris(hazir_giris),
        .veri_cikis(veri_cikis), .veri_gecerli(veri_gecerli), .veri_al(veri_al),
        .doluluk(doluluk), .ozet_gecerli(ozet_gecerli), .adim_sayisi(adim_sayisi),
        .toplam(toplam), .en_kucuk(en_kucuk), .en_buyuk(en_buyuk),
        .hazir_goruldu(hazir_goruldu), .tasma(tasma)
    );

    always #5 saat = ~saat;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic adim();
        @(posedge saat);
        #1;
    endtask

    task automatic ozet_bekle(input string etiket, input int a, input int t, input int mn,
                              input int mx, input int hz, input int ts);
        kontrol({etiket, "_ozet_gecerli"}, 32'(ozet_gecerli), 1);
        kontrol({etiket, "_adim"},  32'(adim_sayisi), a);
        kontrol({etiket, "_toplam"}, 32'(toplam), t);
        kontrol({etiket, "_min"},   32'(en_kucuk), mn);
        kontrol({etiket, "_max"},   32'(en_buyuk), mx);
        kontrol({etiket, "_hazir"}, 32'(hazir_goruldu), hz);
        kontrol({etiket, "_tasma"}, 32'(tasma), ts);
    endtask

    initial begin
        int t1 [4];
        t1 = '{0, 3, 2, 5};

        // Reset state
        #2;
        kontrol("rst_doluluk", 32'(doluluk), 0);
        kontrol("rst_gecerli", 32'(veri_gecerli), 0);
        kontrol("rst_ozet", 32'(ozet_gecerli), 0);
        kontrol("rst_adim", 32'(adim_sayisi), 0);
        kontrol("rst_toplam", 32'(toplam), 0);
        adim();
        reset = 1'b1;
        adim();

        // 1: basic session streaming through with veri_al=1
        veri_al = 1'b1;
        mesgul_giris = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sonuc_giris = 8'(t1[i]);
            adim();
            kontrol("t1_veri", 32'(veri_cikis), 32'(t1[i]));
            kontrol("t1_doluluk", 32'(doluluk), 1);
            kontrol("t1_ozet_yok", 32'(ozet_gecerli), 0);
        end
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t1", 4, 10, 0, 5, 0, 0);
        kontrol("t1_bos", 32'(veri_gecerli), 0);
        adim();
        kontrol("t1_tek_darbe", 32'(ozet_gecerli), 0);

        // 2: overflow with no consumer
        veri_al = 1'b0;
        mesgul_giris = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sonuc_giris = 8'(i);
            adim();
            kontrol("t2_doluluk", 32'(doluluk), (i > 8) ? 8 : i);
        end
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t2", 10, 55, 1, 10, 0, 1);
        adim();
        veri_al = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            kontrol("t2_bosalt", 32'(veri_cikis), i);
            adim();
        end
        kontrol("t2_gecerli_dustu", 32'(veri_gecerli), 0);

        // 3: full FIFO with simultaneous push and pop
        veri_al = 1'b0;
        mesgul_giris = 1'b1;
        for (int i = 11; i <= 18; i++) begin
            sonuc_giris = 8'(i);
            adim();
        end
        kontrol("t3_dolu", 32'(doluluk), 8);
        veri_al = 1'b1;
        for (int j = 0; j < 5; j++) begin
            kontrol("t3_bas", 32'(veri_cikis), 11 + j);
            sonuc_giris = 8'(19 + j);
            adim();
            kontrol("t3_doluluk", 32'(doluluk), 8);
        end
        kontrol("t3_bas_son", 32'(veri_cikis), 16);
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t3", 13, 11+12+13+14+15+16+17+18+19+20+21+22+23, 11, 23, 0, 0);
        for (int i = 17; i <= 23; i++) begin
            kontrol("t3_sira", 32'(veri_cikis), i);
            adim();
        end
        kontrol("t3_bos", 32'(veri_gecerli), 0);

        // 4: hazir flag
        mesgul_giris = 1'b1;
        sonuc_giris = 8'd250; hazir_giris = 1'b0; adim();
        sonuc_giris = 8'd243; hazir_giris = 1'b1; adim();
        sonuc_giris = 8'd244; hazir_giris = 1'b0; adim();
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t4a", 3, 737, 243, 250, 1, 0);
        adim();
        mesgul_giris = 1'b1;
        sonuc_giris = 8'd100; adim();
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t4b", 1, 100, 100, 100, 0, 0);
        adim();

        // 5: back-to-back sessions, one idle cycle between them
        mesgul_giris = 1'b1;
        sonuc_giris = 8'd50; adim();
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t5a", 1, 50, 50, 50, 0, 0);
        mesgul_giris = 1'b1;
        sonuc_giris = 8'd7; adim();
        kontrol("t5_ozet_bitti", 32'(ozet_gecerli), 0);
        kontrol("t5_ilk_ornek", 32'(veri_cikis), 7);
        kontrol("t5_ozet_tutuldu", 32'(toplam), 50);
        sonuc_giris = 8'd9; adim();
        mesgul_giris = 1'b0;
        adim();
        ozet_bekle("t5b", 2, 16, 7, 9, 0, 0);
        adim();

        // 6: asynchronous reset in the middle of a session
        veri_al = 1'b0;
        mesgul_giris = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sonuc_giris = 8'(i);
            adim();
        end
        kontrol("t6_doluluk", 32'(doluluk), 3);
        #2 reset = 1'b0;
        #1;
        kontrol("t6_doluluk_sifir", 32'(doluluk), 0);
        kontrol("t6_gecerli_sifir", 32'(veri_gecerli), 0);
        kontrol("t6_veri_sifir", 32'(veri_cikis), 0);
        kontrol("t6_adim_sifir", 32'(adim_sayisi), 0);
        kontrol("t6_toplam_sifir", 32'(toplam), 0);
        kontrol("t6_min_sifir", 32'(en_kucuk), 0);
        kontrol("t6_max_sifir", 32'(en_buyuk), 0);
        kontrol("t6_ozet_sifir", 32'(ozet_gecerli), 0);
        mesgul_giris = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adim();
            kontrol("t6_ozet_yok", 32'(ozet_gecerli), 0);
            kontrol("t6_bos_kal", 32'(veri_gecerli), 0);
        end
        kontrol("t6_adim_kal", 32'(adim_sayisi), 0);

        $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
